ctrl_sequencer: RTL
===================

Name: ctrl_sequencer

Overview:
Hardwired control unit that sequences the register datapath: the PC, MAR, MBR, IR, ACC and ALU blocks.
- Runs fetch / decode / execute as a Moore FSM.
- Drives the one-hot transfer controls C1–C15, the ALU opcode/enable, the memory write strobe and the halt line.
- Sits beside the register top and the external bus at the same hierarchy level.
- Consumes the IR opcode, the ALU flags and the memory ready handshake.

Parameters:
OPC_W, 8, opcode width from IR
FLAG_W, 5, ALU flag width
FLAG_N_BIT, 1, index of the ACC-negative flag within i_flags

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_cpu_start  input  1  level; leaving IDLE requires it high
i_ir_opcode  input  8  opcode from IR (valid from the cycle after C14)
i_flags  input  5  ALU flags; bit FLAG_N_BIT = result/ACC negative
i_mem_ready  input  1  memory read data valid / write accepted
o_C1..o_C15  output  1 each  datapath transfer strobes (C13 = MBR->data bus / memory write)
o_alu_op  output  4  [3] enable, [2:0] op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MPY
o_ctrl_halt  output  1  high while halted
o_cpu_running  output  1  high in every state except IDLE and HALTED
o_user_sample  output  1  one-cycle pulse at instruction retire
o_state  output  4  current state, for debug

Behaviour:
Reset and output timing:
- Reset is asynchronous and active-low: state goes to IDLE; all outputs are 0.
- All outputs are registered-state decodes (Moore). Each strobe is high for exactly the cycle(s) spent in the state that names it; all other strobes are 0.

Opcodes (i_ir_opcode):
- 01 STORE, 02 LOAD, 03 ADD, 04 SUB, 05 JMPGEZ, 06 JMP, 07 HALT, 08 MPY, 09 AND, 0A OR.
- Any other value is a NOP.

States and transitions:
- IDLE: → F_PC when i_cpu_start=1.
- F_PC: C2 (MAR<=PC, PC<=PC+1). → F_MEM.
- F_MEM: C5. Hold while i_mem_ready=0, with C5 held. → F_IR on ready.
- F_IR: C4. → DECODE.
- DECODE: C14, C15 (MBR<=address field). → next state by opcode:
  - JMP → JUMP.
  - JMPGEZ → JUMP if i_flags[FLAG_N_BIT]=0, else RETIRE.
  - HALT → HALTED.
  - NOP → RETIRE.
  - All others → ADDR.
  - The opcode is sampled in the cycle after C14, so DECODE lasts 2 cycles (DEC0 asserts C14/C15; DEC1 branches).
  - i_flags is sampled in DEC1.
- ADDR: C8. → ST_MBR for STORE, else RD.
- RD: C5, wait on i_mem_ready as in F_MEM. → LD_WB for LOAD, else ALU.
- LD_WB: C11. → RETIRE.
- ALU: C6, C7, o_alu_op = {1, op}. → WB.
- WB: C9 for ADD/SUB/AND/OR; C10 for MPY. → RETIRE.
- ST_MBR: C12. → ST_WR.
- ST_WR: C13, held until i_mem_ready=1. → RETIRE.
- JUMP: C3. → RETIRE.
- RETIRE: o_user_sample=1. → F_PC if i_cpu_start=1, else IDLE.
- HALTED: o_ctrl_halt=1, all strobes 0. Left only by reset.

Cycle counts with zero memory wait (F_PC through RETIRE inclusive):
- NOP 6; JMP 7; JMPGEZ taken 7, not taken 6.
- LOAD 9; STORE 9; ALU ops 10.
- Each wait cycle adds 1.

Boundary conditions:
- i_cpu_start dropping mid-instruction: the instruction completes; the CPU stops at RETIRE.
- Reset mid-wait: immediate IDLE; no strobe glitch after reset deassertion.
- o_ctrl_halt is never 1 together with any strobe.
- i_mem_ready high in the first cycle of a wait state: zero wait.

Test Plan:
- Reset, hold i_cpu_start=0 for 10 cycles → state IDLE, all outputs 0; raise start → next cycle C2=1 for exactly 1 cycle.
- LOAD (02), ready always 1 → strobe order C2, C5, C4, C14+C15, –, C8, C5, C11, user_sample; 9 cycles total.
- ADD (03) with i_mem_ready low 3 cycles in RD → C5 held 4 cycles, then C6+C7 with o_alu_op=4'b1000, then C9; total 13 cycles.
- MPY (08) → o_alu_op=4'b1100 in ALU, then C10 (not C9).
- JMPGEZ (05) with flags[1]=0 → C3 asserted once. With flags[1]=1 → no C3, user_sample after DEC1.
- STORE (01), ready low 2 cycles in ST_WR → C12 then C13 held 3 cycles.
- HALT (07) → o_ctrl_halt=1 and o_cpu_running=0 indefinitely; async reset mid-F_MEM → all outputs 0 immediately.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the register datapath.
// Moore FSM: every strobe is a pure decode of the current state (plus the latched opcode).
module ctrl_sequencer #(
  parameter int OPC_W      = 8,
  parameter int FLAG_W     = 5,
  parameter int FLAG_N_BIT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cpu_start,
  input  logic [OPC_W-1:0] i_ir_opcode,
  input  logic [FLAG_W-1:0] i_flags,
  input  logic             i_mem_ready,
  output logic             o_C1,
  output logic             o_C2,
  output logic             o_C3,
  output logic             o_C4,
  output logic             o_C5,
  output logic             o_C6,
  output logic             o_C7,
  output logic             o_C8,
  output logic             o_C9,
  output logic             o_C10,
  output logic             o_C11,
  output logic             o_C12,
  output logic             o_C13,
  output logic             o_C14,
  output logic             o_C15,
  output logic [3:0]       o_alu_op,
  output logic             o_ctrl_halt,
  output logic             o_cpu_running,
  output logic             o_user_sample,
  output logic [3:0]       o_state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_F_PC   = 4'd1,
    S_F_MEM  = 4'd2,
    S_F_IR   = 4'd3,
    S_DEC0   = 4'd4,
    S_DEC1   = 4'd5,
    S_ADDR   = 4'd6,
    S_RD     = 4'd7,
    S_LD_WB  = 4'd8,
    S_ALU    = 4'd9,
    S_WB     = 4'd10,
    S_ST_MBR = 4'd11,
    S_ST_WR  = 4'd12,
    S_JUMP   = 4'd13,
    S_RETIRE = 4'd14,
    S_HALTED = 4'd15
  } state_t;

  localparam logic [OPC_W-1:0] OP_STORE  = OPC_W'(8'h01);
  localparam logic [OPC_W-1:0] OP_LOAD   = OPC_W'(8'h02);
  localparam logic [OPC_W-1:0] OP_ADD    = OPC_W'(8'h03);
  localparam logic [OPC_W-1:0] OP_SUB    = OPC_W'(8'h04);
  localparam logic [OPC_W-1:0] OP_JMPGEZ = OPC_W'(8'h05);
  localparam logic [OPC_W-1:0] OP_JMP    = OPC_W'(8'h06);
  localparam logic [OPC_W-1:0] OP_HALT   = OPC_W'(8'h07);
  localparam logic [OPC_W-1:0] OP_MPY    = OPC_W'(8'h08);
  localparam logic [OPC_W-1:0] OP_AND    = OPC_W'(8'h09);
  localparam logic [OPC_W-1:0] OP_OR     = OPC_W'(8'h0A);

  state_t           state;
  state_t           state_nxt;
  logic [OPC_W-1:0] opc;
  logic [15:1]      c;
  logic             unused_flags;

  // Only the negative flag steers the sequence; the rest are ignored here.
  assign unused_flags = ^i_flags;

  function automatic logic [2:0] alu_code(input logic [OPC_W-1:0] op);
    case (op)
      OP_SUB:  alu_code = 3'b001;
      OP_AND:  alu_code = 3'b010;
      OP_OR:   alu_code = 3'b011;
      OP_MPY:  alu_code = 3'b100;
      default: alu_code = 3'b000;
    endcase
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Opcode is captured once in DEC1 so later execute states need not trust IR.
  always_ff @(posedge i_clk) begin
    if (state == S_DEC1) opc <= i_ir_opcode;
  end

  always_comb begin
    state_nxt     = state;
    c             = '0;
    o_alu_op      = 4'b0000;
    o_ctrl_halt   = 1'b0;
    o_user_sample = 1'b0;
    case (state)
      S_IDLE:   if (i_cpu_start) state_nxt = S_F_PC;
      S_F_PC:   begin c[2] = 1'b1; state_nxt = S_F_MEM; end
      S_F_MEM:  begin c[5] = 1'b1; if (i_mem_ready) state_nxt = S_F_IR; end
      S_F_IR:   begin c[4] = 1'b1; state_nxt = S_DEC0; end
      S_DEC0:   begin c[14] = 1'b1; c[15] = 1'b1; state_nxt = S_DEC1; end
      S_DEC1: begin
        case (i_ir_opcode)
          OP_JMP:    state_nxt = S_JUMP;
          OP_JMPGEZ: state_nxt = i_flags[FLAG_N_BIT] ? S_RETIRE : S_JUMP;
          OP_HALT:   state_nxt = S_HALTED;
          OP_STORE, OP_LOAD, OP_ADD, OP_SUB,
          OP_MPY, OP_AND, OP_OR: state_nxt = S_ADDR;
          default:   state_nxt = S_RETIRE;
        endcase
      end
      S_ADDR:   begin c[8] = 1'b1; state_nxt = (opc == OP_STORE) ? S_ST_MBR : S_RD; end
      S_RD: begin
        c[5] = 1'b1;
        if (i_mem_ready) state_nxt = (opc == OP_LOAD) ? S_LD_WB : S_ALU;
      end
      S_LD_WB:  begin c[11] = 1'b1; state_nxt = S_RETIRE; end
      S_ALU: begin
        c[6] = 1'b1; c[7] = 1'b1;
        o_alu_op  = {1'b1, alu_code(opc)};
        state_nxt = S_WB;
      end
      S_WB: begin
        if (opc == OP_MPY) c[10] = 1'b1;
        else               c[9]  = 1'b1;
        state_nxt = S_RETIRE;
      end
      S_ST_MBR: begin c[12] = 1'b1; state_nxt = S_ST_WR; end
      S_ST_WR:  begin c[13] = 1'b1; if (i_mem_ready) state_nxt = S_RETIRE; end
      S_JUMP:   begin c[3] = 1'b1; state_nxt = S_RETIRE; end
      S_RETIRE: begin
        o_user_sample = 1'b1;
        state_nxt     = i_cpu_start ? S_F_PC : S_IDLE;
      end
      S_HALTED: o_ctrl_halt = 1'b1;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign o_cpu_running = (state != S_IDLE) && (state != S_HALTED);
  assign o_state       = state;

  assign o_C1  = c[1];
  assign o_C2  = c[2];
  assign o_C3  = c[3];
  assign o_C4  = c[4];
  assign o_C5  = c[5];
  assign o_C6  = c[6];
  assign o_C7  = c[7];
  assign o_C8  = c[8];
  assign o_C9  = c[9];
  assign o_C10 = c[10];
  assign o_C11 = c[11];
  assign o_C12 = c[12];
  assign o_C13 = c[13];
  assign o_C14 = c[14];
  assign o_C15 = c[15];

endmodule
